game_timer: RTL
===============

Name: game_timer

Overview:
- Consumer end of the game tick interface: receives the 0.1 s `game_clk` pulse stream from the game clock generator.
- Implements a loadable BCD countdown timer (SS.t format: two seconds digits, one tenths digit).
- Drives the display digits and tells game logic when time has expired.
- Sits between the tick generator and the 7-segment and game-control logic.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flops on `game_clk`; legal range 2-3.
- DEFAULT_SEC, 60: seconds value loaded at reset; legal range 0-99, stored as BCD.
- WARN_TENTHS, 50: warning threshold in tenths (50 = 5.0 s); used only with the optional feature.

Ports:
- CLOCK50M  input  1  system clock, 50 MHz.
- KEY0  input  1  reset, asynchronous, active-high.
- game_clk  input  1  tick from the game clock generator; one tick per rising edge.
- load  input  1  load request, single-cycle strobe.
- load_sec  input  8  BCD seconds to load ([7:4] tens, [3:0] ones).
- load_tenths  input  4  BCD tenths to load.
- start  input  1  start or resume strobe.
- pause  input  1  pause strobe.
- sec_tens  output  4  BCD seconds tens digit.
- sec_ones  output  4  BCD seconds ones digit.
- tenths  output  4  BCD tenths digit.
- running  output  1  high while in RUN state.
- time_up  output  1  sticky; high in EXPIRED state.
- done_pulse  output  1  one-cycle pulse on the transition to EXPIRED.
- tick_count  output  10  number of ticks consumed while running; wraps.

Behaviour:
- Reset (KEY0=1, asynchronous):
  - State is IDLE.
  - sec_tens/sec_ones hold DEFAULT_SEC in BCD; tenths = 0.
  - running, time_up, done_pulse and tick_count are all 0.
  - Synchronizer flops and the edge-detect flop are cleared.
- Tick detection:
  - `game_clk` passes through SYNC_STAGES flops, then a rising-edge detector.
  - `tick` is an internal one-cycle strobe.
  - Latency from `game_clk` rise to digit update is SYNC_STAGES+1 CLOCK50M cycles.
  - A level held high counts as one tick only.
- States: IDLE, RUN, PAUSED, EXPIRED.
- IDLE:
  - load: digits <= load value.
  - start: if count != 00.0, go to RUN; if count == 00.0, go to EXPIRED and pulse done_pulse.
  - load and start in the same cycle: the load applies and the start is ignored.
- RUN:
  - On tick: decrement by one tenth with BCD borrow (tenths 0 -> 9 borrows from ones; ones 0 -> 9 borrows from tens).
  - On tick: tick_count <= tick_count+1, mod 1024.
  - When the decrement result is 00.0: go to EXPIRED, time_up <= 1, done_pulse <= 1 for exactly that cycle.
  - pause: go to PAUSED. A tick in the same cycle is applied first.
  - load is ignored in RUN.
  - start is ignored in RUN.
- PAUSED:
  - Ticks are ignored.
  - load: digits <= load value.
  - start: same rules as IDLE.
  - start and pause in the same cycle: pause wins; stay in PAUSED.
- EXPIRED:
  - Digits hold 00.0 and ticks are ignored.
  - load: new value loaded, time_up cleared, go to IDLE.
  - start without load: stay in EXPIRED; no new done_pulse.
- Load value rules: any BCD digit > 9 is clamped to 9 (e.g. load_sec=8'hA7 loads 97).
- tick_count clears only on reset.
- `running` equals (state == RUN) and is registered.
- All outputs are registered.

Optional Feature:
- Macro: GAME_TIMER_WARN_EN.
- When defined, adds output `warn` (1 bit):
  - In RUN or PAUSED with remaining time <= WARN_TENTHS tenths and > 0, `warn` toggles on every consumed tick, giving a 0.2 s blink period.
  - `warn` is forced to 0 in IDLE and EXPIRED, and at reset.
  - Remaining tenths are computed as tens*100 + ones*10 + tenths in an 11-bit compare.
- When undefined: the port and its logic are absent and all other behaviour is identical.

Test Plan:
- Reset default: assert KEY0 mid-operation, release -> digits 6,0,0; state IDLE; time_up=0; tick_count=0; no tick counted while KEY0=1.
- Basic countdown: load 8'h01/4'h2, start, 12 game_clk pulses -> each digit update lands SYNC_STAGES+1 cycles after the pulse edge; sequence 1.2, 1.1 … 0.1, 0.0; done_pulse high exactly 1 cycle on the 12th tick; time_up=1; tick_count=12.
- Borrow chain: load 8'h10/4'h0, start, 1 tick -> digits 0,9,9.
- Pause and strobe collisions:
  - Running at 5.3: pause and tick in the same cycle -> 5.2, then PAUSED; 3 further ticks -> still 5.2.
  - In PAUSED, start and pause in the same cycle -> stays PAUSED.
  - start alone -> RUN resumes.
- Zero and invalid loads:
  - load 00.0 then start -> EXPIRED immediately with one done_pulse.
  - Extra start -> no second pulse.
  - load 8'hFA/4'hC -> 99.9, IDLE, time_up=0.
- GAME_TIMER_WARN_EN: load 0.7, WARN_TENTHS=5, start -> warn stays 0 until remaining <= 0.5, then toggles on each tick; warn=0 at 00.0/EXPIRED. Without the macro, the same stimulus produces the same digit sequence.

Source files
------------

// File: rtl/game_timer.sv
// game_timer: loadable SS.t BCD countdown driven by a synchronized 0.1 s game_clk tick.
// Optional blinking low-time warning output is enabled with GAME_TIMER_WARN_EN.
module game_timer #(
  parameter int SYNC_STAGES = 2,
  parameter int DEFAULT_SEC = 60,
  parameter int WARN_TENTHS = 50
) (
  input  logic       CLOCK50M,
  input  logic       KEY0,
  input  logic       game_clk,
  input  logic       load,
  input  logic [7:0] load_sec,
  input  logic [3:0] load_tenths,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] tenths,
  output logic       running,
  output logic       time_up,
  output logic       done_pulse,
  output logic [9:0] tick_count
`ifdef GAME_TIMER_WARN_EN
  ,
  output logic       warn
`endif
);

  localparam logic [3:0] DEF_TENS = 4'(DEFAULT_SEC / 10);
  localparam logic [3:0] DEF_ONES = 4'(DEFAULT_SEC % 10);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_EXPIRED} state_t;
  state_t r_state;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_q;
  logic                   w_tick;
  logic [3:0]             w_dec_tens, w_dec_ones, w_dec_tenths;
  logic                   w_dec_zero, w_cnt_zero;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // A held-high game_clk yields exactly one tick via the edge detector.
  always_ff @(posedge CLOCK50M or posedge KEY0) begin
    if (KEY0) begin
      r_sync   <= '0;
      r_sync_q <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], game_clk};
      r_sync_q <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_tick = r_sync[SYNC_STAGES-1] & ~r_sync_q;

  always_comb begin
    w_dec_tens   = sec_tens;
    w_dec_ones   = sec_ones;
    w_dec_tenths = tenths - 4'd1;
    if (tenths == 4'd0) begin
      w_dec_tenths = 4'd9;
      w_dec_ones   = sec_ones - 4'd1;
      if (sec_ones == 4'd0) begin
        w_dec_ones = 4'd9;
        w_dec_tens = sec_tens - 4'd1;
      end
    end
  end

  assign w_dec_zero = ({w_dec_tens, w_dec_ones, w_dec_tenths} == 12'h000);
  assign w_cnt_zero = ({sec_tens, sec_ones, tenths} == 12'h000);

`ifdef GAME_TIMER_WARN_EN
  logic [10:0] w_dec_rem;
  assign w_dec_rem = 11'(w_dec_tens) * 11'd100 + 11'(w_dec_ones) * 11'd10 + 11'(w_dec_tenths);
`endif

  always_ff @(posedge CLOCK50M or posedge KEY0) begin
    if (KEY0) begin
      r_state    <= S_IDLE;
      sec_tens   <= DEF_TENS;
      sec_ones   <= DEF_ONES;
      tenths     <= 4'd0;
      running    <= 1'b0;
      time_up    <= 1'b0;
      done_pulse <= 1'b0;
      tick_count <= '0;
`ifdef GAME_TIMER_WARN_EN
      warn       <= 1'b0;
`endif
    end else begin
      done_pulse <= 1'b0;
      case (r_state)
        S_IDLE, S_PAUSED: begin
          if (load) begin
            sec_tens <= clamp9(load_sec[7:4]);
            sec_ones <= clamp9(load_sec[3:0]);
            tenths   <= clamp9(load_tenths);
          end else if (start && !(pause && r_state == S_PAUSED)) begin
            if (w_cnt_zero) begin
              r_state    <= S_EXPIRED;
              time_up    <= 1'b1;
              done_pulse <= 1'b1;
`ifdef GAME_TIMER_WARN_EN
              warn       <= 1'b0;
`endif
            end else begin
              r_state <= S_RUN;
              running <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // The tick is applied before a same-cycle pause takes effect.
          if (w_tick) begin
            sec_tens   <= w_dec_tens;
            sec_ones   <= w_dec_ones;
            tenths     <= w_dec_tenths;
            tick_count <= tick_count + 10'd1;
`ifdef GAME_TIMER_WARN_EN
            warn <= (!w_dec_zero && w_dec_rem <= 11'(WARN_TENTHS)) ? ~warn : 1'b0;
`endif
            if (w_dec_zero) begin
              r_state    <= S_EXPIRED;
              running    <= 1'b0;
              time_up    <= 1'b1;
              done_pulse <= 1'b1;
            end else if (pause) begin
              r_state <= S_PAUSED;
              running <= 1'b0;
            end
          end else if (pause) begin
            r_state <= S_PAUSED;
            running <= 1'b0;
          end
        end
        S_EXPIRED: begin
          if (load) begin
            sec_tens <= clamp9(load_sec[7:4]);
            sec_ones <= clamp9(load_sec[3:0]);
            tenths   <= clamp9(load_tenths);
            time_up  <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
